// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester logic-op arbiter.
// Op encoding, FSM state encoding and statistics counter width.
package alu_arb_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int CNT_W = 8;

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational WIDTH-bit AND/OR/NAND/XOR slice.
// Shared by both requesters; no carry between bits.
module alu_logic_unit
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_XOR:  y = a ^ b;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin arbiter in front of one shared logic unit.
// Optional per-requester grant counters under ALU_ARB_STATS_EN.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    state_t           state;
    logic             rr;
    logic [1:0]       lat_op;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic             lat_id;
    logic [WIDTH-1:0] alu_y;
    logic             idle;
    logic             gnt0;
    logic             gnt1;

    // rst_n gating keeps both readys low while reset is held
    assign idle = rst_n && (state == ST_IDLE);
    assign gnt0 = idle && req0_valid && (!req1_valid || !rr);
    assign gnt1 = idle && req1_valid && (!req0_valid || rr);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign res_valid  = (state == ST_DONE);

    alu_logic_unit #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op (lat_op),
        .a  (lat_a),
        .b  (lat_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr       <= 1'b0;
            lat_op   <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_id   <= 1'b0;
            res_data <= '0;
            res_id   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        state  <= ST_EXEC;
                        rr     <= gnt0;
                        lat_op <= gnt1 ? req1_op : req0_op;
                        lat_a  <= gnt1 ? req1_a : req0_a;
                        lat_b  <= gnt1 ? req1_b : req0_b;
                        lat_id <= gnt1;
                    end
                end
                ST_EXEC: begin
                    res_data <= alu_y;
                    res_id   <= lat_id;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt0 && gnt_cnt0 != {CNT_W{1'b1}}) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (gnt1 && gnt_cnt1 != {CNT_W{1'b1}}) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed plus randomized bench for alu_req_arbiter with a behavioural model.
// Counter checks compile in only when ALU_ARB_STATS_EN is defined.
module tb_alu_req_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready;
    logic [W-1:0] res_data;
    logic         res_id;
`ifdef ALU_ARB_STATS_EN
    logic [7:0]   gnt_cnt0, gnt_cnt1;
`endif

    int tests = 0;
    int fails = 0;

    // model state: who won the last grant (1 after reset so req0 wins a tie)
    int last_w = 1;
    int mcnt0 = 0;
    int mcnt1 = 0;
    // winner as observed on the DUT ready outputs
    int dut_w = -1;
    int dut_g0 = 0;
    int dut_g1 = 0;

    alu_req_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ref_op(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = ~(a & b);
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_w = 1;
        mcnt0  = 0;
        mcnt1  = 0;
    endtask

    // One full transaction: present requests, expect grant, result, handshake.
    task automatic do_op(input bit v0, input bit v1,
                         input logic [1:0] o0, input logic [1:0] o1,
                         input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int stall);
        int w;
        logic [W-1:0] e;
        @(negedge clk);
        req0_valid = v0; req1_valid = v1;
        req0_op = o0; req1_op = o1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        res_ready = 1'b0;
        #1;
        if (!v0 && !v1) begin
            chk("idle_rdy0", req0_ready, 1'b0);
            chk("idle_rdy1", req1_ready, 1'b0);
            chk("idle_resv", res_valid, 1'b0);
            return;
        end
        if (v0 && !v1)      w = 0;
        else if (v1 && !v0) w = 1;
        else                w = 1 - last_w;
        e = (w == 0) ? ref_op(o0, a0, b0) : ref_op(o1, a1, b1);
        chk("grant0", req0_ready, w == 0);
        chk("grant1", req1_ready, w == 1);
        chk("accept_resv", res_valid, 1'b0);
        dut_w = req1_ready ? 1 : (req0_ready ? 0 : -1);
        if (req0_ready) dut_g0++;
        if (req1_ready) dut_g1++;
        last_w = w;
        if (w == 0 && mcnt0 < 255) mcnt0++;
        if (w == 1 && mcnt1 < 255) mcnt1++;
        @(negedge clk);
        chk("exec_rdy0", req0_ready, 1'b0);
        chk("exec_rdy1", req1_ready, 1'b0);
        chk("exec_resv", res_valid, 1'b0);
        @(negedge clk);
        chk("done_resv", res_valid, 1'b1);
        chk("done_data", res_data, e);
        chk("done_id", res_id, w[0]);
        chk("done_rdy", {req0_ready, req1_ready}, 2'b00);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_resv", res_valid, 1'b1);
            chk("stall_data", res_data, e);
            chk("stall_id", res_id, w[0]);
            chk("stall_rdy", {req0_ready, req1_ready}, 2'b00);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("ret_resv", res_valid, 1'b0);
    endtask

    initial begin
        int prev;
        logic [1:0] ro0, ro1;
        logic [W-1:0] ra0, rb0, ra1, rb1;

        rst_n = 1'b0;
        res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #12;
        chk("rst_resv", res_valid, 1'b0);
        chk("rst_data", res_data, 4'h0);
        chk("rst_id", res_id, 1'b0);
        chk("rst_rdy", {req0_ready, req1_ready}, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // tie right after reset: req0 first, then req1
        do_op(1, 1, 2'b11, 2'b00, 4'hA, 4'h6, 4'hC, 4'hA, 0);
        chk("tie1_data", res_data, 4'hC);
        do_op(1, 1, 2'b11, 2'b00, 4'hA, 4'h6, 4'hC, 4'hA, 0);
        chk("tie2_data", res_data, 4'h8);

        do_op(1, 0, 2'b10, 2'b00, 4'hF, 4'h6, 4'h0, 4'h0, 0);
        chk("nand_data", res_data, 4'h9);

        do_op(0, 1, 2'b00, 2'b01, 4'h0, 4'h0, 4'h5, 4'h2, 5);

        for (int n = 0; n < 30; n++) begin
            ro0 = 2'($urandom); ro1 = 2'($urandom);
            ra0 = 4'($urandom); rb0 = 4'($urandom);
            ra1 = 4'($urandom); rb1 = 4'($urandom);
            do_op(1'($urandom), 1'($urandom), ro0, ro1,
                  ra0, rb0, ra1, rb1, int'($urandom_range(0, 2)));
        end

`ifdef ALU_ARB_STATS_EN
        chk("mid_cnt0", gnt_cnt0, mcnt0[7:0]);
        chk("mid_cnt1", gnt_cnt1, mcnt1[7:0]);
`endif

        dut_g0 = 0;
        dut_g1 = 0;
        for (int n = 0; n < 20; n++) begin
            prev = dut_w;
            ro0 = 2'($urandom); ro1 = 2'($urandom);
            ra0 = 4'($urandom); rb0 = 4'($urandom);
            ra1 = 4'($urandom); rb1 = 4'($urandom);
            do_op(1, 1, ro0, ro1, ra0, rb0, ra1, rb1, 0);
            if (n > 0) chk("starve_alt", dut_w != prev, 1'b1);
        end
        chk("starve_g0", dut_g0, 10);
        chk("starve_g1", dut_g1, 10);

        // valid withdrawn before the edge: no grant, rr untouched
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("drop_resv", res_valid, 1'b0);
        chk("drop_rdy", {req0_ready, req1_ready}, 2'b00);
        do_op(1, 1, 2'b01, 2'b01, 4'h1, 4'h2, 4'h4, 4'h8, 0);

        // reset while in EXEC
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'b01; req0_a = 4'hF; req0_b = 4'hF;
        req1_op = 2'b01; req1_a = 4'hF; req1_b = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rexec_resv", res_valid, 1'b0);
        chk("rexec_data", res_data, 4'h0);
        chk("rexec_rdy", {req0_ready, req1_ready}, 2'b00);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("post_rst_resv", res_valid, 1'b0);
            chk("post_rst_data", res_data, 4'h0);
        end
        do_op(1, 1, 2'b00, 2'b11, 4'h3, 4'h6, 4'h1, 4'h1, 0);
        chk("post_rst_tie", res_id, 1'b0);

`ifdef ALU_ARB_STATS_EN
        chk("stat_rst_cnt0", gnt_cnt0, 8'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("stat_clr0", gnt_cnt0, 8'd0);
        chk("stat_clr1", gnt_cnt1, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 300; n++) begin
            do_op(0, 1, 2'b00, 2'b11, 4'h0, 4'h0, 4'h3, 4'h5, 0);
        end
        chk("stat_cnt1", gnt_cnt1, 8'd255);
        chk("stat_cnt0", gnt_cnt0, 8'd0);
        chk("stat_model1", gnt_cnt1, mcnt1[7:0]);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
